// File: rtl/dmem_store_buffer.sv
// Data-memory store buffer: posts core stores into an in-order FIFO drained to a
// valid/ready bus; loads bypass unrelated stores and wait for same-word stores.
module dmem_store_buffer #(
  parameter int SB_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        read,
  input  logic [31:0]                 read_address,
  input  logic                        write,
  input  logic [31:0]                 write_address,
  input  logic [31:0]                 DATA_out,
  input  logic [1:0]                  size,
  output logic [31:0]                 DATA_in,
  output logic                        rd_valid,
  output logic                        stall,
  output logic                        mem_req_valid,
  input  logic                        mem_req_ready,
  output logic                        mem_req_we,
  output logic [31:0]                 mem_req_addr,
  output logic [31:0]                 mem_req_wdata,
  output logic [3:0]                  mem_req_be,
  input  logic                        mem_rsp_valid,
  input  logic [31:0]                 mem_rsp_rdata,
  output logic [$clog2(SB_DEPTH):0]   sb_count,
  output logic                        err_misalign,
  output logic                        err_overflow
);
  localparam int PW = $clog2(SB_DEPTH);
  localparam int CW = PW + 1;

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] LD_DRAIN = 2'd1;
  localparam logic [1:0] LD_REQ   = 2'd2;
  localparam logic [1:0] LD_RSP   = 2'd3;

  logic [29:0]         sb_addr [SB_DEPTH];
  logic [3:0]          sb_be   [SB_DEPTH];
  logic [31:0]         sb_data [SB_DEPTH];
  logic [SB_DEPTH-1:0] sb_vld;
  logic [PW-1:0]       rd_ptr, wr_ptr;
  logic [CW-1:0]       count;
  logic [1:0]          state;
  logic [29:0]         ld_addr;

  logic [3:0]  enc_be;
  logic [31:0] enc_data;
  logic        enc_mis;
  logic        full, push, pop, drain_en, rd_go;
  logic        hit_rd, hit_ld;

  always_comb begin
    enc_be   = 4'b1111;
    enc_data = DATA_out;
    enc_mis  = 1'b0;
    case (size)
      2'b00: begin
        enc_be   = 4'b0001 << write_address[1:0];
        enc_data = {4{DATA_out[7:0]}};
      end
      2'b01: begin
        enc_be   = write_address[1] ? 4'b1100 : 4'b0011;
        enc_data = {2{DATA_out[15:0]}};
        enc_mis  = write_address[0];
      end
      default: enc_mis = |write_address[1:0];
    endcase
  end

  assign full     = (count == CW'(SB_DEPTH));
  assign push     = write && !full;
  assign stall    = (state != IDLE) || full;
  assign rd_go    = read && !stall;
  assign drain_en = ((state == IDLE) || (state == LD_DRAIN)) && (count != '0);
  assign pop      = drain_en && mem_req_ready;

  // An entry popping this edge no longer blocks the load; a store pushed this
  // edge does, since it is older than a same-cycle load.
  always_comb begin
    hit_rd = push && (write_address[31:2] == read_address[31:2]);
    hit_ld = push && (write_address[31:2] == ld_addr);
    for (int i = 0; i < SB_DEPTH; i++) begin
      if (sb_vld[i] && !(pop && rd_ptr == PW'(i))) begin
        if (sb_addr[i] == read_address[31:2]) hit_rd = 1'b1;
        if (sb_addr[i] == ld_addr)            hit_ld = 1'b1;
      end
    end
  end

  // The load preempts any drain request once in LD_REQ; the head store is
  // re-presented unchanged on return to IDLE.
  always_comb begin
    mem_req_valid = drain_en || (state == LD_REQ);
    mem_req_we    = drain_en;
    mem_req_addr  = '0;
    mem_req_wdata = '0;
    mem_req_be    = '0;
    if (state == LD_REQ) begin
      mem_req_addr = {ld_addr, 2'b00};
      mem_req_be   = 4'b1111;
    end else if (drain_en) begin
      mem_req_addr  = {sb_addr[rd_ptr], 2'b00};
      mem_req_wdata = sb_data[rd_ptr];
      mem_req_be    = sb_be[rd_ptr];
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      sb_addr[wr_ptr] <= write_address[31:2];
      sb_be[wr_ptr]   <= enc_be;
      sb_data[wr_ptr] <= enc_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sb_vld       <= '0;
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      count        <= '0;
      err_misalign <= 1'b0;
      err_overflow <= 1'b0;
    end else begin
      if (pop) begin
        sb_vld[rd_ptr] <= 1'b0;
        rd_ptr         <= rd_ptr + 1'b1;
      end
      if (push) begin
        sb_vld[wr_ptr] <= 1'b1;
        wr_ptr         <= wr_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
      if (write && enc_mis) err_misalign <= 1'b1;
      if (write && full)    err_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      ld_addr  <= '0;
      DATA_in  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= 1'b0;
      case (state)
        IDLE: if (rd_go) begin
          ld_addr <= read_address[31:2];
          state   <= hit_rd ? LD_DRAIN : LD_REQ;
        end
        LD_DRAIN: if (!hit_ld) state <= LD_REQ;
        LD_REQ:   if (mem_req_ready) state <= LD_RSP;
        default: if (mem_rsp_valid) begin
          DATA_in  <= mem_rsp_rdata;
          rd_valid <= 1'b1;
          state    <= IDLE;
        end
      endcase
    end
  end

  assign sb_count = count;
endmodule

// File: tb/tb_dmem_store_buffer.sv
// Directed bench for dmem_store_buffer: store encoding, overflow, load hazards,
// load bypass ordering, misalign flag and mid-load reset.
module tb_dmem_store_buffer;
  logic        clk = 1'b0;
  logic        reset;
  logic        read, write;
  logic [31:0] read_address, write_address, DATA_out;
  logic [1:0]  size;
  logic [31:0] DATA_in;
  logic        rd_valid, stall;
  logic        mem_req_valid, mem_req_ready, mem_req_we;
  logic [31:0] mem_req_addr, mem_req_wdata;
  logic [3:0]  mem_req_be;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_rdata;
  logic [2:0]  sb_count;
  logic        err_misalign, err_overflow;

  int vectors = 0;
  int miscompares = 0;

  dmem_store_buffer #(.SB_DEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .read(read), .read_address(read_address),
    .write(write), .write_address(write_address), .DATA_out(DATA_out), .size(size),
    .DATA_in(DATA_in), .rd_valid(rd_valid), .stall(stall),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_we(mem_req_we),
    .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata), .mem_req_be(mem_req_be),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata),
    .sb_count(sb_count), .err_misalign(err_misalign), .err_overflow(err_overflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic st(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
    write = 1'b1; write_address = a; DATA_out = d; size = sz;
  endtask

  initial begin
    reset = 1'b0; read = 1'b0; write = 1'b0; read_address = '0; write_address = '0;
    DATA_out = '0; size = 2'b00; mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_rdata = '0;
    tick(); tick();
    chk("rst_count", sb_count, 0);
    chk("rst_stall", stall, 0);
    chk("rst_reqv", mem_req_valid, 0);
    chk("rst_data", DATA_in, 0);
    chk("rst_rdv", rd_valid, 0);
    chk("rst_errs", {err_misalign, err_overflow}, 0);
    reset = 1'b1;
    tick();

    // byte store lane replication
    st(32'h1001, 32'hAB, 2'b00);
    tick(); write = 1'b0;
    chk("b_we", mem_req_we, 1);
    chk("b_addr", mem_req_addr, 32'h1000);
    chk("b_be", mem_req_be, 4'b0010);
    chk("b_wdata", mem_req_wdata, 32'hABABABAB);
    mem_req_ready = 1'b1; tick(); mem_req_ready = 1'b0;
    chk("b_drained", sb_count, 0);

    // fill and overflow
    for (int i = 0; i < 4; i++) begin
      st(32'h10 + 32'(4 * i), 32'h100 + 32'(i), 2'b10);
      tick();
    end
    write = 1'b0;
    chk("full_count", sb_count, 4);
    chk("full_stall", stall, 1);
    chk("ovf_before", err_overflow, 0);
    st(32'h50, 32'hDEAD, 2'b10);
    tick(); write = 1'b0;
    chk("ovf_set", err_overflow, 1);
    chk("ovf_count", sb_count, 4);
    mem_req_ready = 1'b1; tick();
    chk("drain1_count", sb_count, 3);
    chk("drain1_addr", mem_req_addr, 32'h14);
    tick(); tick(); tick(); mem_req_ready = 1'b0;
    chk("drain_empty", sb_count, 0);

    // same-cycle store+load to one word: store must go first
    st(32'h20, 32'h100, 2'b10);
    read = 1'b1; read_address = 32'h20;
    tick(); write = 1'b0; read = 1'b0;
    chk("haz_stall", stall, 1);
    chk("haz_we", mem_req_we, 1);
    chk("haz_wdata", mem_req_wdata, 32'h100);
    tick(); tick();
    chk("haz_hold_addr", mem_req_addr, 32'h20);
    mem_req_ready = 1'b1; tick();
    chk("haz_ld_we", {mem_req_valid, mem_req_we}, 2'b10);
    chk("haz_ld_addr", mem_req_addr, 32'h20);
    chk("haz_ld_be", mem_req_be, 4'b1111);
    tick(); mem_req_ready = 1'b0;
    chk("haz_rsp_wait", {mem_req_valid, rd_valid}, 0);
    mem_rsp_valid = 1'b1; mem_rsp_rdata = 32'h100;
    tick(); mem_rsp_valid = 1'b0;
    chk("haz_rdv", rd_valid, 1);
    chk("haz_data", DATA_in, 32'h100);
    tick();
    chk("haz_rdv_pulse", rd_valid, 0);
    chk("haz_data_hold", DATA_in, 32'h100);

    // no-hazard latency: read@N, req@N+1, rsp@N+2, rd_valid@N+3
    mem_req_ready = 1'b1;
    read = 1'b1; read_address = 32'h202;
    tick(); read = 1'b0;
    chk("lat_req", {mem_req_valid, mem_req_we}, 2'b10);
    chk("lat_addr", mem_req_addr, 32'h200);
    tick();
    mem_rsp_valid = 1'b1; mem_rsp_rdata = 32'hCAFEF00D;
    tick(); mem_rsp_valid = 1'b0; mem_req_ready = 1'b0;
    chk("lat_rdv", rd_valid, 1);
    chk("lat_data", DATA_in, 32'hCAFEF00D);

    // load to another word bypasses buffered stores
    st(32'h40, 32'h11111111, 2'b10); tick();
    st(32'h40, 32'h22222222, 2'b10); tick(); write = 1'b0;
    read = 1'b1; read_address = 32'h80;
    tick(); read = 1'b0;
    chk("byp_ld", {mem_req_valid, mem_req_we}, 2'b10);
    chk("byp_addr", mem_req_addr, 32'h80);
    chk("byp_count", sb_count, 2);
    mem_req_ready = 1'b1; tick(); mem_req_ready = 1'b0;
    chk("byp_rsp_count", sb_count, 2);
    mem_rsp_valid = 1'b1; mem_rsp_rdata = 32'h5A5A5A5A;
    tick(); mem_rsp_valid = 1'b0;
    chk("byp_data", DATA_in, 32'h5A5A5A5A);
    chk("byp_st1", mem_req_wdata, 32'h11111111);
    chk("byp_st1_addr", mem_req_addr, 32'h40);
    mem_req_ready = 1'b1; tick();
    chk("byp_st2", mem_req_wdata, 32'h22222222);
    tick(); mem_req_ready = 1'b0;
    chk("byp_empty", sb_count, 0);
    chk("mis_before", err_misalign, 0);

    // misaligned half store
    st(32'h3, 32'hBEEF, 2'b01);
    tick(); write = 1'b0;
    chk("mis_set", err_misalign, 1);
    chk("mis_be", mem_req_be, 4'b1100);
    chk("mis_addr", mem_req_addr, 32'h0);
    chk("mis_wdata", mem_req_wdata, 32'hBEEFBEEF);
    mem_req_ready = 1'b1; tick(); mem_req_ready = 1'b0;

    // reset while waiting in LD_RSP
    read = 1'b1; read_address = 32'h300;
    mem_req_ready = 1'b1; tick(); read = 1'b0;
    tick(); mem_req_ready = 1'b0;
    chk("pre_rst_stall", stall, 1);
    reset = 1'b0; #1;
    chk("mid_rst_stall", stall, 0);
    chk("mid_rst_data", DATA_in, 0);
    chk("mid_rst_errs", {err_misalign, err_overflow}, 0);
    chk("mid_rst_reqv", mem_req_valid, 0);
    tick();
    reset = 1'b1;
    mem_rsp_valid = 1'b1; mem_rsp_rdata = 32'h77777777;
    tick(); mem_rsp_valid = 1'b0;
    chk("late_rsp_rdv", rd_valid, 0);
    chk("late_rsp_data", DATA_in, 0);
    chk("late_rsp_stall", stall, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
